// File: rtl/uart_pkg.sv
// Shared UART-side types and helpers: arbiter state encoding, default start timeout
// and the rotate-priority pick used by both the TX arbiter and the RX read scheduler.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    localparam int ARB_TIMEOUT_DEFAULT = 64;
    localparam int RR_MAX_REQ          = 16;

    // First set lane scanning upward from ptr, modulo num; result is {any, idx}.
    function automatic logic [4:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr, input int num);
        logic [4:0] v_res;
        logic [4:0] v_pos;
        v_res = 5'd0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            v_pos = {1'b0, ptr} + 5'(k);
            if (v_pos >= 5'(num)) begin
                v_pos = v_pos - 5'(num);
            end else begin
                v_pos = v_pos;
            end
            if ((k < num) && !v_res[4] && req[v_pos[3:0]]) begin
                v_res = {1'b1, v_pos[3:0]};
            end else begin
                v_res = v_res;
            end
        end
        return v_res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the lowest requesting index at or above the
// pointer wins, wrapping around. Produces one-hot grant, binary index and an any flag.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [15:0] w_req_ext;
    logic [3:0]  w_ptr_ext;
    logic [4:0]  w_pick;

    // Widen to the helper's fixed lane count and decode the pick.
    always_comb begin
        w_req_ext              = 16'd0;
        w_req_ext[NUM_REQ-1:0] = i_req;
        w_ptr_ext              = 4'd0;
        w_ptr_ext[IW-1:0]      = i_ptr;
        w_pick                 = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
        o_any                  = w_pick[4];
        o_idx                  = w_pick[IW-1:0];
        o_gnt                  = {NUM_REQ{1'b0}};
        if (w_pick[4]) begin
            o_gnt[w_pick[IW-1:0]] = 1'b1;
        end else begin
            o_gnt = {NUM_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ clients, one frame per grant,
// with start/busy/complete handshake tracking, start timeout and a saturating frame counter.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int START_TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             Req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
    output logic [NUM_REQ-1:0]             Grant,
    output logic [NUM_REQ-1:0]             Done,
    input  logic                           CTS,
    input  logic                           Tx_Busy,
    output logic [DATA_BITS-1:0]           Tx_Data,
    output logic                           Transmit_Start,
    output logic                           Start_Error,
    output logic [$clog2(NUM_REQ)-1:0]     Owner,
    output logic [15:0]                    Frame_Count
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    arb_state_t            r_state, w_state_nxt;
    logic [IW-1:0]         r_ptr, w_ptr_nxt, w_ptr_inc;
    logic [IW-1:0]         r_owner, w_owner_nxt;
    logic [DATA_BITS-1:0]  r_data, w_data_nxt;
    logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic                  r_ts, w_ts_nxt;
    logic                  r_err, w_err_nxt;
    logic [TW-1:0]         r_cnt, w_cnt_nxt;
    logic [15:0]           r_fc, w_fc_nxt;
    logic [NUM_REQ-1:0]    w_arb_gnt;
    logic [IW-1:0]         w_arb_idx;
    logic                  w_arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .i_req (Req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Next-state and next-output logic for the grant handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_data_nxt  = r_data;
        w_grant_nxt = {NUM_REQ{1'b0}};
        w_done_nxt  = {NUM_REQ{1'b0}};
        w_ts_nxt    = r_ts;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_fc_nxt    = r_fc;
        w_ptr_inc   = (r_owner == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : r_owner + IW'(1);
        case (r_state)
            ARB_IDLE: begin
                // Busy while idle means another user owns the line.
                if (w_arb_any && CTS && !Tx_Busy) begin
                    w_grant_nxt = w_arb_gnt;
                    w_owner_nxt = w_arb_idx;
                    w_data_nxt  = Req_Data[w_arb_idx*DATA_BITS +: DATA_BITS];
                    w_ts_nxt    = 1'b1;
                    w_cnt_nxt   = {TW{1'b0}};
                    w_state_nxt = ARB_START;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_START: begin
                // Busy seen on the expiry cycle still counts as a successful start.
                if (Tx_Busy) begin
                    w_ts_nxt    = 1'b0;
                    w_state_nxt = ARB_BUSY;
                end else if (r_cnt == TW'(START_TIMEOUT - 1)) begin
                    w_ts_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + TW'(1);
                end
            end
            ARB_BUSY: begin
                if (!Tx_Busy) begin
                    w_done_nxt[r_owner] = 1'b1;
                    w_fc_nxt    = (r_fc == 16'hFFFF) ? r_fc : r_fc + 16'd1;
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ARB_IDLE;
                end else begin
                    w_state_nxt = ARB_BUSY;
                end
            end
            default: begin
                w_ts_nxt    = 1'b0;
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= {IW{1'b0}};
            r_owner <= {IW{1'b0}};
            r_data  <= {DATA_BITS{1'b0}};
            r_grant <= {NUM_REQ{1'b0}};
            r_done  <= {NUM_REQ{1'b0}};
            r_ts    <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= {TW{1'b0}};
            r_fc    <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_data  <= w_data_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_ts    <= w_ts_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fc    <= w_fc_nxt;
        end
    end

    assign Grant          = r_grant;
    assign Done           = r_done;
    assign Tx_Data        = r_data;
    assign Transmit_Start = r_ts;
    assign Start_Error    = r_err;
    assign Owner          = r_owner;
    assign Frame_Count    = r_fc;

endmodule
